// File: rtl/spi_main_pkg.sv
// Shared MMIO definitions for the SPI main core: decoder prefix,
// register word addresses and the transfer FSM state type.
package spi_main_pkg;

   localparam logic [5:0] SPI_PREFIX   = 6'h05;

   localparam logic [7:0] ADDR_STATUS  = 8'h00;
   localparam logic [7:0] ADDR_CONTROL = 8'h01;
   localparam logic [7:0] ADDR_TX_DATA = 8'h02;
   localparam logic [7:0] ADDR_RX_DATA = 8'h03;
   localparam logic [7:0] ADDR_CLKDIV  = 8'h04;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SCK_LOW  = 2'd1,
      SCK_HIGH = 2'd2
   } spi_state_t;

endpackage

// File: rtl/spi_main.sv
// SPI mode-0 main controller on the MMIO bus: software chip select,
// programmable SCK half-period divider, single-byte full-duplex transfers.
module spi_main
   import spi_main_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIV = 16'h0004
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        spi_ss,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   spi_state_t  state;
   logic [7:0]  shift_reg;
   logic [7:0]  rx_data;
   logic [2:0]  bit_ctr;
   logic [15:0] div_ctr;
   logic [15:0] clkdiv;
   logic        busy;
   logic        wr_control;
   logic        wr_tx;
   logic        wr_clkdiv;
   logic        unused_wdata;

   assign busy       = (state != IDLE);
   assign wr_control = cs & we & (address == ADDR_CONTROL);
   assign wr_tx      = cs & we & (address == ADDR_TX_DATA);
   assign wr_clkdiv  = cs & we & (address == ADDR_CLKDIV);
   assign ready      = cs;

   // Upper write-data bits have no register behind them.
   assign unused_wdata = ^write_data[31:16];

   // Software chip select; accepted at any time, including mid-transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spi_ss <= 1'b1;
      end else if (wr_control) begin
         spi_ss <= ~write_data[0];
      end
   end

   // Divider register; frozen while a transfer is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clkdiv <= DEFAULT_DIV;
      end else if (wr_clkdiv && !busy) begin
         clkdiv <= write_data[15:0];
      end
   end

   // Transfer FSM: divider, shifter and registered SCK/MOSI.
   // MOSI is refreshed from shift_reg[7] on each falling SCK, which after the
   // rising-edge shift already holds the next outgoing bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         rx_data   <= '0;
         bit_ctr   <= '0;
         div_ctr   <= '0;
         spi_sck   <= 1'b0;
         spi_mosi  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               spi_sck <= 1'b0;
               if (wr_tx) begin
                  shift_reg <= write_data[7:0];
                  spi_mosi  <= write_data[7];
                  bit_ctr   <= '0;
                  div_ctr   <= clkdiv;
                  state     <= SCK_LOW;
               end
            end
            SCK_LOW: begin
               if (div_ctr == 16'd0) begin
                  div_ctr   <= clkdiv;
                  spi_sck   <= 1'b1;
                  shift_reg <= {shift_reg[6:0], spi_miso};
                  state     <= SCK_HIGH;
               end else begin
                  div_ctr <= div_ctr - 16'd1;
               end
            end
            SCK_HIGH: begin
               if (div_ctr == 16'd0) begin
                  div_ctr <= clkdiv;
                  spi_sck <= 1'b0;
                  if (bit_ctr == 3'd7) begin
                     rx_data  <= shift_reg;
                     spi_mosi <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     bit_ctr  <= bit_ctr + 3'd1;
                     spi_mosi <= shift_reg[7];
                     state    <= SCK_LOW;
                  end
               end else begin
                  div_ctr <= div_ctr - 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               spi_sck <= 1'b0;
            end
         endcase
      end
   end

   // Combinational register read mux; zero when not selected or unmapped.
   always_comb begin
      read_data = '0;
      if (cs) begin
         case (address)
            ADDR_STATUS:  read_data = {31'd0, busy};
            ADDR_CONTROL: read_data = {31'd0, ~spi_ss};
            ADDR_RX_DATA: read_data = {24'd0, rx_data};
            ADDR_CLKDIV:  read_data = {16'd0, clkdiv};
            default:      read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_main.sv
// Self-checking bench for spi_main: register vector table, directed
// multi-cycle sequences and randomized transfers against a slave model.
module tb_spi_main;
   import spi_main_pkg::*;

   localparam int BOUND = 20000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic        spi_ss;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;

   int vectors = 0;
   int miscompares = 0;

   // Slave-side model state
   logic        loopback = 1'b0;
   logic [7:0]  slave_byte = '0;
   logic [15:0] mosi_cap = '0;
   int          rise_cnt = 0;
   time         t_first = 0;
   time         t_last = 0;

   spi_main #(.DEFAULT_DIV(16'h0004)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cs         (cs),
      .we         (we),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .spi_ss     (spi_ss),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   always #5 clk = ~clk;

   // Slave: capture MOSI on each rising SCK, present next MISO bit MSB first
   always @(posedge spi_sck) begin
      if (rise_cnt == 0) t_first = $time;
      t_last   = $time;
      mosi_cap = {mosi_cap[14:0], spi_mosi};
      rise_cnt = rise_cnt + 1;
   end

   always_comb begin
      spi_miso = 1'b0;
      if (loopback) spi_miso = spi_mosi;
      else          spi_miso = slave_byte[7 - (rise_cnt % 8)];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus write: drive during the low phase, hold across one rising edge
   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      cs = 1'b1; we = 1'b1; address = a; write_data = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; write_data = '0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic r);
      cs = 1'b1; we = 1'b0; address = a;
      #1;
      d = read_data;
      r = ready;
      cs = 1'b0;
   endtask

   // Count cycles with busy=1, starting in the current cycle
   task automatic wait_idle(output int n);
      logic [31:0] d;
      logic        r;
      n = 0;
      forever begin
         bus_read(ADDR_STATUS, d, r);
         if (!d[0] || n > BOUND) break;
         n++;
         @(negedge clk);
      end
   endtask

   // One transfer checked against the specification-level expectations
   task automatic run_transfer(input logic [7:0] tx, input logic [15:0] div,
                               input logic [7:0] sb, input logic lb);
      int          n;
      logic [31:0] d;
      logic        r;
      bus_write(ADDR_CLKDIV, {16'd0, div});
      loopback   = lb;
      slave_byte = sb;
      rise_cnt   = 0;
      bus_write(ADDR_TX_DATA, {24'hABCDEF, tx});
      wait_idle(n);
      check("busy_cycles", n, 16 * (int'(div) + 1));
      check("sck_rises", rise_cnt, 8);
      check("mosi_bits", {24'd0, mosi_cap[7:0]}, {24'd0, tx});
      check("sck_span", 32'(t_last - t_first), 32'(7 * 2 * (int'(div) + 1) * 10));
      bus_read(ADDR_RX_DATA, d, r);
      check("rx_data", d, lb ? {24'd0, tx} : {24'd0, sb});
      @(negedge clk);
   endtask

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vtab[12];

   initial begin
      logic [31:0] d;
      logic        r;
      int          n1, n2;
      logic [7:0]  tx, sb;
      logic [15:0] dv;

      vtab[0]  = '{1'b0, ADDR_STATUS,  32'h0,        32'h0};
      vtab[1]  = '{1'b0, ADDR_CONTROL, 32'h0,        32'h0};
      vtab[2]  = '{1'b0, ADDR_CLKDIV,  32'h0,        32'h4};
      vtab[3]  = '{1'b0, ADDR_RX_DATA, 32'h0,        32'h0};
      vtab[4]  = '{1'b1, ADDR_CLKDIV,  32'hABCD0007, 32'h7};
      vtab[5]  = '{1'b1, ADDR_CONTROL, 32'hFFFFFFFE, 32'h0};
      vtab[6]  = '{1'b1, ADDR_CONTROL, 32'h00000003, 32'h1};
      vtab[7]  = '{1'b1, 8'h07,        32'hDEADBEEF, 32'h0};
      vtab[8]  = '{1'b0, ADDR_TX_DATA, 32'h0,        32'h0};
      vtab[9]  = '{1'b1, ADDR_CONTROL, 32'h0,        32'h0};
      vtab[10] = '{1'b1, ADDR_CLKDIV,  32'h0000FFFF, 32'hFFFF};
      vtab[11] = '{1'b1, ADDR_CLKDIV,  32'h00000000, 32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ss", {31'd0, spi_ss}, 32'h1);
      check("rst_sck", {31'd0, spi_sck}, 32'h0);
      check("rst_mosi", {31'd0, spi_mosi}, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Register table
      foreach (vtab[i]) begin
         if (vtab[i].wr) bus_write(vtab[i].addr, vtab[i].wdata);
         bus_read(vtab[i].addr, d, r);
         check("reg_vec", d, vtab[i].exp);
         check("reg_ready", {31'd0, r}, 32'h1);
         @(negedge clk);
      end
      check("cs_low_read", read_data, 32'h0);

      // Chip select timing
      check("ss_before", {31'd0, spi_ss}, 32'h1);
      bus_write(ADDR_CONTROL, 32'h1);
      check("ss_assert", {31'd0, spi_ss}, 32'h0);
      bus_write(ADDR_CONTROL, 32'h0);
      check("ss_release", {31'd0, spi_ss}, 32'h1);

      // Loopback, CLKDIV=0, 0xA5
      run_transfer(8'hA5, 16'd0, 8'h00, 1'b1);
      // CLKDIV=3, slave returns 0x3C
      run_transfer(8'h96, 16'd3, 8'h3C, 1'b0);

      // Writes during a transfer are ignored
      bus_write(ADDR_CLKDIV, 32'h1);
      loopback = 1'b1;
      rise_cnt = 0;
      bus_write(ADDR_TX_DATA, 32'h81);
      bus_write(ADDR_TX_DATA, 32'hFF);
      bus_write(ADDR_CLKDIV, 32'h10);
      bus_read(ADDR_CLKDIV, d, r);
      check("clkdiv_locked", d, 32'h1);
      wait_idle(n1);
      check("busy_ignore_len", n1 < BOUND ? 32'd1 : 32'd0, 32'd1);
      check("ignore_mosi", {24'd0, mosi_cap[7:0]}, 32'h81);
      check("ignore_rises", rise_cnt, 8);
      bus_read(ADDR_RX_DATA, d, r);
      check("ignore_rx", d, 32'h81);
      @(negedge clk);

      // Back-to-back transfers, CLKDIV=0, loopback
      bus_write(ADDR_CLKDIV, 32'h0);
      rise_cnt = 0;
      bus_write(ADDR_TX_DATA, 32'h5A);
      wait_idle(n1);
      bus_write(ADDR_TX_DATA, 32'hC3);
      wait_idle(n2);
      check("b2b_busy1", n1, 16);
      check("b2b_busy2", n2, 16);
      check("b2b_rises", rise_cnt, 16);
      check("b2b_mosi", {16'd0, mosi_cap}, 32'h5AC3);
      check("b2b_span", 32'(t_last - t_first), 32'd310);
      bus_read(ADDR_RX_DATA, d, r);
      check("b2b_rx", d, 32'hC3);
      @(negedge clk);

      // Randomized transfers against the slave model
      for (int k = 0; k < 8; k++) begin
         tx = 8'($urandom);
         sb = 8'($urandom);
         dv = 16'($urandom_range(0, 4));
         run_transfer(tx, dv, sb, 1'b0);
      end

      // Reset in the middle of a transfer
      bus_write(ADDR_CONTROL, 32'h1);
      bus_write(ADDR_CLKDIV, 32'h2);
      loopback = 1'b0;
      slave_byte = 8'hFF;
      rise_cnt = 0;
      bus_write(ADDR_TX_DATA, 32'hFF);
      repeat (5) @(negedge clk);
      check("pre_rst_mosi", {31'd0, spi_mosi}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_ss", {31'd0, spi_ss}, 32'h1);
      check("mid_rst_sck", {31'd0, spi_sck}, 32'h0);
      check("mid_rst_mosi", {31'd0, spi_mosi}, 32'h0);
      bus_read(ADDR_STATUS, d, r);
      check("mid_rst_status", d, 32'h0);
      bus_read(ADDR_CLKDIV, d, r);
      check("mid_rst_clkdiv", d, 32'h4);
      bus_read(ADDR_RX_DATA, d, r);
      check("mid_rst_rx", d, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_sck", {31'd0, spi_sck}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
